// File: rtl/if_fetch_if.sv
// Fetch-stage bus bundle: instruction-memory request/response, branch
// redirect from execute, and the valid/ready handshake towards decode.
interface if_fetch_if #(
    parameter int unsigned W = 32
);
    // Instruction memory
    logic         IMEM_req;
    logic [W-1:0] IMEM_addr;
    logic         IMEM_gnt;
    logic         IMEM_rvalid;
    logic [W-1:0] IMEM_rdata;
    // Redirect from execute
    logic         Branch_taken;
    logic [W-1:0] Branch_target;
    // Decode handshake
    logic         ID_ready;
    logic         IF_valid;
    logic [W-1:0] IF_Instruction;
    logic [W-1:0] IF_PC;

    // Fetch stage side
    modport master (
        output IMEM_req, IMEM_addr, IF_valid, IF_Instruction, IF_PC,
        input  IMEM_gnt, IMEM_rvalid, IMEM_rdata, Branch_taken, Branch_target, ID_ready
    );

    // Environment side: memory, execute and decode
    modport slave (
        input  IMEM_req, IMEM_addr, IF_valid, IF_Instruction, IF_PC,
        output IMEM_gnt, IMEM_rvalid, IMEM_rdata, Branch_taken, Branch_target, ID_ready
    );
endinterface

// File: rtl/if_fetch.sv
// Instruction-fetch stage. Owns the PC, issues word requests to instruction
// memory under a credit limit, buffers returned words with their PCs and
// hands them to decode over a valid/ready handshake. A branch redirect
// flushes the buffer and turns every in-flight response into one to drop.
module if_fetch #(
    parameter int unsigned               REG_DATA_WIDTH = 32,
    parameter logic [REG_DATA_WIDTH-1:0] RESET_PC       = '0,
    parameter int unsigned               FIFO_DEPTH     = 2
) (
    input  logic       clk,
    input  logic       resetn,
    if_fetch_if.master bus
);
    localparam int unsigned   W       = REG_DATA_WIDTH;
    localparam int unsigned   AW      = $clog2(FIFO_DEPTH);
    localparam int unsigned   CW      = AW + 2;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    // RUN: no stale responses outstanding. DRAIN: dropping stale responses.
    typedef enum logic {RUN, DRAIN} state_t;

    state_t        state;
    logic [W-1:0]  pc;

    // Address queue: PCs of granted requests awaiting their response
    logic [W-1:0]  aq_mem [FIFO_DEPTH];
    logic [AW-1:0] aq_wr;
    logic [AW-1:0] aq_rd;
    logic [CW-1:0] pend;

    // Instruction buffer: returned words with their PCs
    logic [W-1:0]  buf_data [FIFO_DEPTH];
    logic [W-1:0]  buf_pc   [FIFO_DEPTH];
    logic [AW-1:0] buf_wr;
    logic [AW-1:0] buf_rd;
    logic [CW-1:0] buf_cnt;

    // Responses still owed for requests made before a redirect
    logic [CW-1:0] discard;

    logic          draining;
    logic          rsp_legal;
    logic          rsp_drop;
    logic          rsp_keep;
    logic          xfer;
    logic          gnt_fire;
    logic [CW-1:0] occupancy;
    logic [CW-1:0] discard_br;

    assign draining  = (state == DRAIN);
    assign rsp_legal = bus.IMEM_rvalid & (draining | (pend != '0));
    assign rsp_drop  = bus.IMEM_rvalid & draining;
    assign rsp_keep  = bus.IMEM_rvalid & ~draining & (pend != '0);

    assign bus.IF_valid       = (buf_cnt != '0) & ~bus.Branch_taken;
    assign bus.IF_Instruction = buf_data[buf_rd];
    assign bus.IF_PC          = buf_pc[buf_rd];
    assign xfer               = bus.IF_valid & bus.ID_ready;

    // A slot released this cycle by a transfer to decode or by a dropped
    // stale word is already free for a new request; this is what lets a
    // 1-cycle memory sustain one fetch per cycle with only two slots.
    // Without a grant the occupancy never grows, so a raised request holds.
    assign occupancy    = pend + buf_cnt + discard - CW'(xfer) - CW'(rsp_drop);
    assign bus.IMEM_req = resetn & (occupancy < DEPTH_C) & ~bus.Branch_taken;
    assign bus.IMEM_addr = pc;
    assign gnt_fire      = bus.IMEM_req & bus.IMEM_gnt;

    // On redirect every pending request becomes stale; a response arriving
    // in the same cycle is consumed by that cycle and is not owed any more.
    assign discard_br = discard + pend - CW'(rsp_legal);

    // PC, drain FSM, occupancy counters and queue pointers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pc      <= RESET_PC;
            state   <= RUN;
            discard <= '0;
            pend    <= '0;
            buf_cnt <= '0;
            aq_wr   <= '0;
            aq_rd   <= '0;
            buf_wr  <= '0;
            buf_rd  <= '0;
        end else if (bus.Branch_taken) begin
            pc      <= bus.Branch_target & ~W'(3);
            discard <= discard_br;
            state   <= (discard_br != '0) ? DRAIN : RUN;
            pend    <= '0;
            buf_cnt <= '0;
            aq_wr   <= '0;
            aq_rd   <= '0;
            buf_wr  <= '0;
            buf_rd  <= '0;
        end else begin
            if (gnt_fire) begin
                pc    <= pc + W'(4);
                aq_wr <= aq_wr + AW'(1);
            end
            if (rsp_keep) begin
                aq_rd  <= aq_rd + AW'(1);
                buf_wr <= buf_wr + AW'(1);
            end
            if (xfer) begin
                buf_rd <= buf_rd + AW'(1);
            end
            if (rsp_drop) begin
                discard <= discard - CW'(1);
                state   <= (discard == CW'(1)) ? RUN : DRAIN;
            end
            pend    <= pend + CW'(gnt_fire) - CW'(rsp_keep);
            buf_cnt <= buf_cnt + CW'(rsp_keep) - CW'(xfer);
        end
    end

    // NOTE: the buffer storage is reset because its head drives
    // IF_Instruction/IF_PC, which must read zero out of reset; the address
    // queue storage never reaches an output and is left without reset.
    // Buffer storage: capture each kept response with its request PC
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                buf_data[i] <= '0;
                buf_pc[i]   <= '0;
            end
        end else if (rsp_keep && !bus.Branch_taken) begin
            buf_data[buf_wr] <= bus.IMEM_rdata;
            buf_pc[buf_wr]   <= aq_mem[aq_rd];
        end
    end

    // Address queue storage: record the PC of every granted request
    always_ff @(posedge clk) begin
        if (gnt_fire) begin
            aq_mem[aq_wr] <= pc;
        end
    end
endmodule

// File: tb/tb_if_fetch.sv
// Self-checking bench for if_fetch: a latency-programmable in-order memory,
// randomised grant/ready/redirect stimulus, and a queue-based reference
// model of the fetch stage that predicts every output each cycle.
module tb_if_fetch;
    localparam int unsigned W        = 32;
    localparam int          DEPTH    = 2;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    typedef struct {
        logic [31:0] ins;
        logic [31:0] pc;
    } entry_t;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    logic clk    = 1'b0;
    logic resetn = 1'b1;
    always #5 clk = ~clk;

    if_fetch_if #(.W(W)) bus ();

    if_fetch #(
        .REG_DATA_WIDTH(W),
        .RESET_PC      (RESET_PC),
        .FIFO_DEPTH    (DEPTH)
    ) dut (
        .clk   (clk),
        .resetn(resetn),
        .bus   (bus)
    );

    int n_tests;
    int n_fail;
    int cyc;

    // Stimulus knobs
    int          lat;
    int          gnt_pct;
    int          rdy_pct;
    int          br_pm;
    logic        br_next;
    logic [31:0] tgt_next;

    // Values observed at the last sample point
    logic        obs_req;
    logic        obs_valid;
    logic [31:0] obs_addr;
    logic [31:0] obs_pc;
    logic [31:0] obs_ins;

    // Reference model of the fetch stage
    logic [31:0] m_pc;
    logic [31:0] m_pend[$];
    entry_t      m_buf[$];
    int          m_disc;

    // Memory model
    mreq_t       mem_q[$];
    int          last_due;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A5A, a[31:16] + a[15:0] + 16'h1234};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic reset_model();
        m_pc   = RESET_PC;
        m_pend.delete();
        m_buf.delete();
        m_disc = 0;
        mem_q.delete();
        last_due = 0;
    endtask

    // One clock cycle: drive inputs, predict and compare at the falling
    // edge, then advance both the memory and the reference model.
    task automatic cycle();
        logic        br;
        logic        rdy;
        logic        gnt;
        logic        rv;
        logic        legal;
        logic        exp_req;
        logic        exp_valid;
        logic [31:0] tgt;
        logic [31:0] rdata;
        int          occ;
        int          due;
        mreq_t       r;
        entry_t      e;

        br      = br_next || ($urandom_range(999) < br_pm);
        tgt     = br_next ? tgt_next : $urandom();
        br_next = 1'b0;
        rdy     = ($urandom_range(99) < rdy_pct);
        gnt     = ($urandom_range(99) < gnt_pct);
        rv      = (mem_q.size() > 0) && (mem_q[0].due <= cyc);
        rdata   = rv ? mem_word(mem_q[0].addr) : $urandom();

        bus.Branch_taken  = br;
        bus.Branch_target = tgt;
        bus.ID_ready      = rdy;
        bus.IMEM_gnt      = gnt;
        bus.IMEM_rvalid   = rv;
        bus.IMEM_rdata    = rdata;

        @(negedge clk);
        obs_req   = bus.IMEM_req;
        obs_valid = bus.IF_valid;
        obs_addr  = bus.IMEM_addr;
        obs_pc    = bus.IF_PC;
        obs_ins   = bus.IF_Instruction;

        exp_valid = (m_buf.size() > 0) && !br;
        occ = m_pend.size() + m_buf.size() + m_disc
              - ((exp_valid && rdy) ? 1 : 0) - ((rv && m_disc > 0) ? 1 : 0);
        exp_req = (occ < DEPTH) && !br;

        check("IMEM_req", 32'(obs_req), 32'(exp_req));
        if (exp_req) check("IMEM_addr", obs_addr, m_pc);
        check("IF_valid", 32'(obs_valid), 32'(exp_valid));
        if (exp_valid) begin
            check("IF_PC", obs_pc, m_buf[0].pc);
            check("IF_Instruction", obs_ins, m_buf[0].ins);
        end

        // Memory: retire the response shown, accept a granted request
        if (rv) void'(mem_q.pop_front());
        if (obs_req && gnt) begin
            due = cyc + lat;
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            r.addr = obs_addr;
            r.due  = due;
            mem_q.push_back(r);
        end

        // Reference model step
        legal = (m_pend.size() > 0) || (m_disc > 0);
        if (rv) check("rvalid_legal", 32'(legal), 32'd1);
        if (br) begin
            m_disc = m_disc + m_pend.size() - ((rv && legal) ? 1 : 0);
            m_pend.delete();
            m_buf.delete();
            m_pc = tgt & 32'hFFFF_FFFC;
        end else begin
            if (exp_valid && rdy) void'(m_buf.pop_front());
            if (rv && m_disc > 0) begin
                m_disc--;
            end else if (rv && m_pend.size() > 0) begin
                e.pc  = m_pend.pop_front();
                e.ins = rdata;
                m_buf.push_back(e);
            end
            if (exp_req && gnt) begin
                m_pend.push_back(m_pc);
                m_pc = m_pc + 32'd4;
            end
        end

        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Asynchronous reset pulse in mid-cycle; outputs must clear at once
    task automatic apply_reset();
        #2;
        resetn = 1'b0;
        #1;
        check("rst_IF_valid", 32'(bus.IF_valid), 32'd0);
        check("rst_IMEM_req", 32'(bus.IMEM_req), 32'd0);
        check("rst_IF_PC", bus.IF_PC, 32'd0);
        check("rst_IF_Instruction", bus.IF_Instruction, 32'd0);
        reset_model();
        @(posedge clk);
        #1;
        resetn = 1'b1;
    endtask

    initial begin
        logic [31:0] first_pc;
        logic [31:0] second_pc;
        int          seen;
        logic        saw_stale;

        n_tests  = 0;
        n_fail   = 0;
        cyc      = 0;
        lat      = 1;
        gnt_pct  = 100;
        rdy_pct  = 100;
        br_pm    = 0;
        br_next  = 1'b0;
        tgt_next = '0;
        bus.IMEM_gnt      = 1'b0;
        bus.IMEM_rvalid   = 1'b0;
        bus.IMEM_rdata    = '0;
        bus.Branch_taken  = 1'b0;
        bus.Branch_target = '0;
        bus.ID_ready      = 1'b0;
        reset_model();

        // Power-on reset
        #1 resetn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("por_IF_valid", 32'(bus.IF_valid), 32'd0);
        check("por_IMEM_req", 32'(bus.IMEM_req), 32'd0);
        check("por_IF_PC", bus.IF_PC, 32'd0);
        check("por_IF_Instruction", bus.IF_Instruction, 32'd0);
        check("por_IMEM_addr", bus.IMEM_addr, RESET_PC);
        resetn = 1'b1;

        // Streaming with 1-cycle memory: back-to-back fetch and delivery
        for (int i = 0; i < 8; i++) begin
            cycle();
            check("stream_addr", obs_addr, 32'(4 * i));
            if (i >= 2) begin
                check("stream_pc", obs_pc, 32'(4 * (i - 2)));
                check("stream_ins", obs_ins, mem_word(32'(4 * (i - 2))));
            end
        end

        // Decode stalled for 5 cycles straight out of reset
        rdy_pct = 0;
        apply_reset();
        repeat (5) cycle();
        check("stall_req", 32'(obs_req), 32'd0);
        check("stall_pc", obs_pc, 32'h0);
        rdy_pct = 100;
        cycle();
        check("resume_pc0", obs_pc, 32'h0);
        check("resume_addr", obs_addr, 32'h8);
        cycle();
        check("resume_pc1", obs_pc, 32'h4);
        repeat (4) cycle();

        // Latency 3: two requests in flight, then redirect to 0x103
        lat      = 3;
        br_next  = 1'b1;
        tgt_next = 32'h10;
        repeat (3) cycle();
        br_next   = 1'b1;
        tgt_next  = 32'h103;
        seen      = 0;
        saw_stale = 1'b0;
        first_pc  = '0;
        second_pc = '0;
        for (int i = 0; i < 30; i++) begin
            cycle();
            if (obs_valid) begin
                if (obs_pc == 32'h10 || obs_pc == 32'h14) saw_stale = 1'b1;
                if (seen == 0) first_pc = obs_pc;
                if (seen == 1) second_pc = obs_pc;
                seen++;
            end
        end
        check("redirect_first_pc", first_pc, 32'h100);
        check("redirect_second_pc", second_pc, 32'h104);
        check("redirect_no_stale", 32'(saw_stale), 32'd0);

        // Redirect colliding with a response and a transfer
        lat = 1;
        repeat (12) cycle();
        br_next  = 1'b1;
        tgt_next = 32'h200;
        cycle();
        check("collide_req", 32'(obs_req), 32'd0);
        check("collide_valid", 32'(obs_valid), 32'd0);
        repeat (8) cycle();
        check("collide_after_pc", obs_pc, 32'h214);

        // PC wrap at the top of the address space
        br_next  = 1'b1;
        tgt_next = 32'hFFFF_FFFE;
        cycle();
        cycle();
        check("wrap_addr_top", obs_addr, 32'hFFFF_FFFC);
        check("wrap_req", 32'(obs_req), 32'd1);
        cycle();
        check("wrap_addr_zero", obs_addr, 32'h0);
        cycle();
        check("wrap_pc_top", obs_pc, 32'hFFFF_FFFC);
        cycle();
        check("wrap_pc_zero", obs_pc, 32'h0);

        // Randomised grants, stalls, redirects and latencies
        gnt_pct = 70;
        rdy_pct = 60;
        br_pm   = 40;
        for (int b = 0; b < 8; b++) begin
            lat = $urandom_range(4, 1);
            repeat (50) cycle();
        end
        gnt_pct = 100;
        rdy_pct = 100;
        br_pm   = 0;

        // Reset mid-stream with a full buffer
        lat = 1;
        repeat (6) cycle();
        rdy_pct = 0;
        repeat (4) cycle();
        check("full_valid", 32'(obs_valid), 32'd1);
        check("full_req", 32'(obs_req), 32'd0);
        apply_reset();
        rdy_pct = 100;
        cycle();
        check("restart_addr", obs_addr, RESET_PC);
        check("restart_req", 32'(obs_req), 32'd1);
        repeat (6) cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
